// File: rtl/xf_load_decoder_if.sv
// Word-port and XF write-bus signals between the CP parser, the Load XF decoder
// and the Transform Unit.
interface xf_load_decoder_if;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned XADDR_W = 12;

  logic               loadStart;
  logic [WORD_W-1:0]  wordData;
  logic               wordValid;
  logic               wordReady;
  logic [XADDR_W-1:0] CPAddr;
  logic [WORD_W-1:0]  CPWriteData;
  logic               CPWriteMatrix;
  logic               CPWriteReg;

  // Upstream parser and XF sink side
  modport master (
    output loadStart, wordData, wordValid,
    input  wordReady, CPAddr, CPWriteData, CPWriteMatrix, CPWriteReg
  );

  // Decoder side
  modport slave (
    input  loadStart, wordData, wordValid,
    output wordReady, CPAddr, CPWriteData, CPWriteMatrix, CPWriteReg
  );
endinterface

// File: rtl/xf_load_decoder.sv
// Decodes CP "Load XF" header + data words into single-word XF matrix/register writes.
// Optional macro XF_LOAD_STATS_EN adds statWords/statTransfers counters.
module xf_load_decoder #(
  parameter logic [15:0] REG_BASE  = 16'h1000,
  parameter logic [15:0] REG_COUNT = 16'h0058
) (
  input  logic              clk,
  input  logic              reset,
  xf_load_decoder_if.slave  bus,
  output logic              busy,
  output logic              loadDone,
  output logic [1:0]        errFlags
`ifdef XF_LOAD_STATS_EN
  ,
  output logic [31:0]       statWords,
  output logic [15:0]       statTransfers
`endif
);

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned XADDR_W = 12;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned LEN_LSB = 16;
  localparam int unsigned LEN_W   = 4;
  localparam logic [ADDR_W:0] REG_END = (ADDR_W+1)'(REG_BASE) + (ADDR_W+1)'(REG_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remain;
  logic [XADDR_W-1:0]  r_cp_addr;
  logic [WORD_W-1:0]   r_cp_data;
  logic                r_wr_mtx;
  logic                r_wr_reg;
  logic                r_busy;
  logic                r_done;
  logic [1:0]          r_err;

  logic                w_ready;
  logic                w_accept;
  logic                w_data_acc;
  logic                w_last;
  logic                w_is_mtx;
  logic                w_is_reg;

  assign w_ready    = (r_state != S_IDLE);
  assign w_accept   = bus.wordValid & w_ready;
  assign w_data_acc = w_accept && (r_state == S_DATA);
  assign w_last     = (r_remain == CNT_W'(1));
  // Classification always looks at the full 16-bit address of the word in flight
  assign w_is_mtx   = (r_addr < REG_BASE);
  assign w_is_reg   = !w_is_mtx && ((ADDR_W+1)'(r_addr) < REG_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_cp_addr <= '0;
      r_cp_data <= '0;
      r_wr_mtx  <= 1'b0;
      r_wr_reg  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= '0;
    end else begin
      r_wr_mtx <= 1'b0;
      r_wr_reg <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= (r_state != S_IDLE);
      if (bus.loadStart && (r_state != S_IDLE)) r_err[1] <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.loadStart) r_state <= S_HEADER;
        end
        S_HEADER: begin
          if (w_accept) begin
            r_addr   <= bus.wordData[ADDR_W-1:0];
            r_remain <= CNT_W'(bus.wordData[LEN_LSB +: LEN_W]) + CNT_W'(1);
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - CNT_W'(1);
            if (w_is_mtx || w_is_reg) begin
              r_cp_addr <= r_addr[XADDR_W-1:0];
              r_cp_data <= bus.wordData;
              r_wr_mtx  <= w_is_mtx;
              r_wr_reg  <= w_is_reg;
            end else begin
              r_err[0] <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wordReady     = w_ready;
  assign bus.CPAddr        = r_cp_addr;
  assign bus.CPWriteData   = r_cp_data;
  assign bus.CPWriteMatrix = r_wr_mtx;
  assign bus.CPWriteReg    = r_wr_reg;
  assign busy              = r_busy;
  assign loadDone          = r_done;
  assign errFlags          = r_err;

`ifdef XF_LOAD_STATS_EN
  logic [31:0] r_stat_words;
  logic [15:0] r_stat_xfers;

  // Word count wraps; transfer count saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_words <= '0;
      r_stat_xfers <= '0;
    end else begin
      if (w_data_acc) r_stat_words <= r_stat_words + 32'd1;
      if (w_data_acc && w_last && (r_stat_xfers != 16'hFFFF))
        r_stat_xfers <= r_stat_xfers + 16'd1;
    end
  end

  assign statWords     = r_stat_words;
  assign statTransfers = r_stat_xfers;
`endif

endmodule

// File: tb/tb_xf_load_decoder.sv
// Self-checking bench for xf_load_decoder: directed test-plan loads plus randomized loads
// checked against a transaction-level model of the expected XF writes.
module tb_xf_load_decoder;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic loadDone;
  logic [1:0] errFlags;
`ifdef XF_LOAD_STATS_EN
  logic [31:0] statWords;
  logic [15:0] statTransfers;
`endif

  always #5 clk = ~clk;

  xf_load_decoder_if bus();

  xf_load_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .loadDone (loadDone),
    .errFlags (errFlags)
`ifdef XF_LOAD_STATS_EN
    ,
    .statWords     (statWords),
    .statTransfers (statTransfers)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected-state model: last written address/data, sticky errors, statistics
  logic [11:0] m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_err;
  int unsigned m_words;
  int unsigned m_xfers;
  logic [31:0] dwords [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = matrix memory, 1 = register space, 2 = unmapped
  function automatic int classify(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai < 'h1000) return 0;
    if (ai < 'h1000 + 'h58) return 1;
    return 2;
  endfunction

  task automatic chk_cycle(input string tag, input bit e_mtx, input bit e_reg,
                           input bit e_done, input bit e_busy);
    chk({tag, "/mtx"},  32'(bus.CPWriteMatrix), 32'(e_mtx));
    chk({tag, "/reg"},  32'(bus.CPWriteReg),    32'(e_reg));
    chk({tag, "/done"}, 32'(loadDone),          32'(e_done));
    chk({tag, "/busy"}, 32'(busy),              32'(e_busy));
    chk({tag, "/addr"}, 32'(bus.CPAddr),        32'(m_addr));
    chk({tag, "/data"}, bus.CPWriteData,        m_data);
    chk({tag, "/err"},  32'(errFlags),          32'(m_err));
`ifdef XF_LOAD_STATS_EN
    chk({tag, "/swords"}, statWords,              32'(m_words));
    chk({tag, "/sxfers"}, 32'(statTransfers),     32'(m_xfers));
`endif
  endtask

  task automatic model_reset();
    m_addr  = '0;
    m_data  = '0;
    m_err   = '0;
    m_words = 0;
    m_xfers = 0;
  endtask

  // stall_mode: 0 none, 1 every third data cycle, 2 random.
  // late_idx: data index whose offer carries a stray loadStart (-1 none).
  // rst_after: reset right after this many accepted data words (0 none).
  task automatic do_load(input string tag, input logic [31:0] hdr, input int stall_mode,
                         input int late_idx, input int rst_after);
    int len, i, cyc, k;
    bit stall, late, e_m, e_r, last;
    logic [15:0] a;
    len = int'(hdr[19:16]) + 1;
    bus.loadStart = 1'b1;
    bus.wordValid = 1'b0;
    tick();
    bus.loadStart = 1'b0;
    chk_cycle({tag, "/start"}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "/rdy_hdr"}, 32'(bus.wordReady), 32'd1);
    bus.wordData  = hdr;
    bus.wordValid = 1'b1;
    tick();
    bus.wordValid = 1'b0;
    chk_cycle({tag, "/hdr"}, 1'b0, 1'b0, 1'b0, 1'b1);
    i = 0;
    cyc = 0;
    while (i < len) begin
      stall = (stall_mode == 1 && (cyc % 3) == 2) ||
              (stall_mode == 2 && $urandom_range(0, 3) == 0);
      cyc++;
      late = (i == late_idx) && !stall;
      chk({tag, "/rdy"}, 32'(bus.wordReady), 32'd1);
      bus.wordValid = !stall;
      bus.wordData  = stall ? $urandom() : dwords[i];
      bus.loadStart = late;
      tick();
      bus.loadStart = 1'b0;
      bus.wordValid = 1'b0;
      if (late) m_err[1] = 1'b1;
      e_m = 1'b0;
      e_r = 1'b0;
      last = 1'b0;
      if (!stall) begin
        a = hdr[15:0] + 16'(i);
        k = classify(a);
        if (k == 2) begin
          m_err[0] = 1'b1;
        end else begin
          e_m = (k == 0);
          e_r = (k == 1);
          m_addr = a[11:0];
          m_data = dwords[i];
        end
        last = (i == len - 1);
        m_words++;
        if (last && m_xfers < 65535) m_xfers++;
        i++;
      end
      chk_cycle({tag, "/dat"}, e_m, e_r, last, 1'b1);
      if (!stall && rst_after != 0 && i == rst_after) begin
        reset = 1'b1;
        bus.wordValid = 1'b1;
        bus.wordData  = dwords[i];
        tick();
        reset = 1'b0;
        model_reset();
        chk_cycle({tag, "/rst"}, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "/rst_rdy"}, 32'(bus.wordReady), 32'd0);
        repeat (3) begin
          tick();
          chk_cycle({tag, "/rst_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
          chk({tag, "/rst_idle_rdy"}, 32'(bus.wordReady), 32'd0);
        end
        bus.wordValid = 1'b0;
        return;
      end
    end
    tick();
    chk_cycle({tag, "/end"}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "/end_rdy"}, 32'(bus.wordReady), 32'd0);
  endtask

  task automatic fill_random();
    for (int j = 0; j < 16; j++) dwords[j] = $urandom();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bases [6];
    logic [31:0] hdr;
    int late;
    bases[0] = 16'h0FF8; bases[1] = 16'h1050; bases[2] = 16'hFFF8;
    bases[3] = 16'h0000; bases[4] = 16'h1000; bases[5] = 16'h2000;

    bus.loadStart = 1'b0;
    bus.wordValid = 1'b0;
    bus.wordData  = '0;
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset/rdy", 32'(bus.wordReady), 32'd0);

    // Words offered while idle must be ignored
    bus.wordValid = 1'b1;
    bus.wordData  = 32'h0000_0010;
    tick();
    bus.wordValid = 1'b0;
    chk_cycle("idle_word", 1'b0, 1'b0, 1'b0, 1'b0);

    dwords[0] = 32'h3F80_0000;
    do_load("single", 32'h0000_0010, 0, -1, 0);
    fill_random();
    do_load("max_stall", 32'h000F_0400, 1, -1, 0);
    fill_random();
    do_load("boundary", 32'h0003_0FFE, 0, -1, 0);
    chk("boundary/err_clean", 32'(errFlags), 32'd0);
`ifdef XF_LOAD_STATS_EN
    chk("stat/words21", statWords, 32'd21);
    chk("stat/xfers3", 32'(statTransfers), 32'd3);
`endif
    fill_random();
    do_load("wrap", 32'h0001_FFFF, 0, -1, 0);
    chk("wrap/err0", 32'(errFlags), 32'd1);
    fill_random();
    do_load("late_start", 32'h0003_1020, 0, 1, 0);
    chk("late_start/err", 32'(errFlags), 32'd3);
    fill_random();
    do_load("late_final", 32'h0001_0020, 0, 1, 0);
    fill_random();
    do_load("mid_reset", 32'h0003_0100, 0, -1, 2);
    fill_random();
    do_load("after_reset", 32'h0000_1004, 0, -1, 0);

    for (int n = 0; n < 30; n++) begin
      fill_random();
      hdr = $urandom();
      if ($urandom_range(0, 3) != 0) hdr[15:0] = bases[$urandom_range(0, 5)];
      late = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31'(hdr[19:16]))) : -1;
      do_load("random", hdr, 2, late, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
